// File: rtl/serial_difference_restorer.sv
// Bit-serial two's-complement adder (Sum = D + B mod 2^WIDTH), LSB first, start/busy/done handshake.
// Optional signed-overflow flag port Ovf is built when SDR_OVF_FLAG_EN is defined.
module serial_difference_restorer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SDR_OVF_FLAG_EN
  ,
  output logic             Ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start; Sum/Cout hold the last result
  // RUN   | one operand bit added per cycle, LSB first
  // DONE  | result valid; start here is accepted back-to-back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             accept, last;
  logic [WIDTH-1:0] d_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;
  logic             s_bit, c_next;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_bit  = d_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (d_q[0] & b_q[0]) | (d_q[0] & carry_q) | (b_q[0] & carry_q);

`ifdef SDR_OVF_FLAG_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SDR_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      d_q     <= D;
      b_q     <= B;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (busy) begin
      d_q     <= d_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= c_next;
      cnt_q   <= cnt_q + 1'b1;
      // sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
      sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
      if (last) begin
        cout_q <= c_next;
`ifdef SDR_OVF_FLAG_EN
        ovf_q  <= carry_q ^ c_next;
`endif
      end
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef SDR_OVF_FLAG_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_difference_restorer.sv
// Self-checking bench for serial_difference_restorer (WIDTH=4); Ovf checked when SDR_OVF_FLAG_EN is defined.
module tb_serial_difference_restorer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] D, B;
  logic         busy, done;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef SDR_OVF_FLAG_EN
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_difference_restorer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .D     (D),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef SDR_OVF_FLAG_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 clk = ~clk;

  // returns {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] d, input logic [W-1:0] b);
    int su, ss;
    logic ovf, c;
    logic [W-1:0] s;
    su  = int'(d) + int'(b);
    ss  = int'($signed(d)) + int'($signed(b));
    s   = W'(su);
    c   = (su >= (1 << W));
    ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    return {ovf, c, s};
  endfunction

  // issues one start pulse, scrambles operand inputs while busy, returns at the negedge of the done cycle
  task automatic do_op(input logic [W-1:0] d, input logic [W-1:0] b,
                       output int edges, output int busy_cycles, output bit ok);
    @(negedge clk);
    D = d; B = b; start = 1'b1;
    edges = 0; busy_cycles = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      D = W'($urandom); B = W'($urandom);
      if (busy) busy_cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int stray;
    reset = 1'b1; start = 1'b0; D = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (Sum !== '0) begin errors++; $display("FAIL reset_sum: got %0d want 0", Sum); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", Cout); end
`ifdef SDR_OVF_FLAG_EN
    checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", Ovf); end
`endif
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL reset_idle_quiet: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_directed();
    logic [W-1:0] dv [4] = '{4'd2, 4'd14, 4'd7, 4'd8};
    logic [W-1:0] bv [4] = '{4'd3, 4'd3, 4'd1, 4'd8};
    logic [W-1:0] sv [4] = '{4'd5, 4'd1, 4'd8, 4'd0};
    logic         cv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         ov [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int edges, bc;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      do_op(dv[i], bv[i], edges, bc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_timeout: got no done want done", i); end
      checks++; if (edges !== W + 1) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, edges, W + 1); end
      checks++; if (bc !== W) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, W); end
      checks++; if (Sum !== sv[i]) begin errors++; $display("FAIL dir%0d_sum: got %0d want %0d", i, Sum, sv[i]); end
      checks++; if (Cout !== cv[i]) begin errors++; $display("FAIL dir%0d_cout: got %b want %b", i, Cout, cv[i]); end
`ifdef SDR_OVF_FLAG_EN
      checks++; if (Ovf !== ov[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b want %b", i, Ovf, ov[i]); end
`else
      if (ov[i] === 1'bx) $display("unexpected x in overflow table");
`endif
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
      checks++; if (Sum !== sv[i]) begin errors++; $display("FAIL dir%0d_sum_hold: got %0d want %0d", i, Sum, sv[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, b;
    logic [W+1:0] exp;
    int edges, bc;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      d = W'($urandom); b = W'($urandom);
      exp = model(d, b);
      do_op(d, b, edges, bc, ok);
      checks++;
      if (!ok || edges !== W + 1 || Sum !== exp[W-1:0] || Cout !== exp[W]) begin
        errors++;
        $display("FAIL rand%0d: D=%0d B=%0d got sum=%0d cout=%b edges=%0d want sum=%0d cout=%b edges=%0d",
                 i, d, b, Sum, Cout, edges, exp[W-1:0], exp[W], W + 1);
      end
`ifdef SDR_OVF_FLAG_EN
      checks++; if (Ovf !== exp[W+1]) begin errors++; $display("FAIL rand%0d_ovf: got %b want %b", i, Ovf, exp[W+1]); end
`endif
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int edges;
    bit ok;
    @(negedge clk);
    D = 4'd2; B = 4'd3; start = 1'b1;
    edges = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = (edges == 2);
      D = (edges == 2) ? 4'd9 : W'($urandom);
      B = (edges == 2) ? 4'd9 : W'($urandom);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++; if (!ok || edges !== W + 1) begin errors++; $display("FAIL busy_ignore_latency: got %0d want %0d", edges, W + 1); end
    checks++; if (Sum !== 4'd5) begin errors++; $display("FAIL busy_ignore_sum: got %0d want 5", Sum); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_no_queue: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1, b1, d2, b2;
    logic [W+1:0] e1x, e2x;
    int e, e1, e2;
    d1 = W'($urandom); b1 = W'($urandom);
    d2 = W'($urandom); b2 = W'($urandom);
    e1x = model(d1, b1); e2x = model(d2, b2);
    @(negedge clk);
    D = d1; B = b1; start = 1'b1;
    e = 0; e1 = -1; e2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (e1 >= 0 && start) begin
        start = 1'b0;
        D = W'($urandom); B = W'($urandom);
      end
      if (done) begin
        if (e1 < 0) begin
          e1 = e;
          checks++; if (Sum !== e1x[W-1:0] || Cout !== e1x[W]) begin errors++;
            $display("FAIL b2b_first: got sum=%0d cout=%b want sum=%0d cout=%b", Sum, Cout, e1x[W-1:0], e1x[W]); end
          D = d2; B = b2;
        end else begin
          e2 = e;
          break;
        end
      end
    end
    start = 1'b0;
    checks++; if (e1 !== W + 1) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", e1, W + 1); end
    checks++; if (e2 - e1 !== W + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", e2 - e1, W + 1); end
    checks++; if (Sum !== e2x[W-1:0] || Cout !== e2x[W]) begin errors++;
      $display("FAIL b2b_second: got sum=%0d cout=%b want sum=%0d cout=%b", Sum, Cout, e2x[W-1:0], e2x[W]); end
  endtask

  task automatic test_reset_mid_run();
    int edges, bc, stray;
    bit ok;
    do_op(4'd14, 4'd3, edges, bc, ok);
    @(negedge clk);
    D = 4'd5; B = 4'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b want 0", busy); end
    checks++; if (Sum !== '0) begin errors++; $display("FAIL midrun_sum: got %0d want 0", Sum); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL midrun_cout: got %b want 0", Cout); end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses want 0", stray); end
    // reset and start together: reset wins
    D = 4'd1; B = 4'd1; start = 1'b1; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority: got busy=%b want 0", busy); end
    do_op(4'd7, 4'd1, edges, bc, ok);
    checks++; if (!ok || edges !== W + 1 || Sum !== 4'd8 || Cout !== 1'b0) begin errors++;
      $display("FAIL after_reset_op: got sum=%0d cout=%b edges=%0d want sum=8 cout=0 edges=%0d", Sum, Cout, edges, W + 1); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; D = '0; B = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
